// File: rtl/alu_mdu_pkg.sv
// Shared types for the execute-stage ALU / multiply-divide unit.
// Holds the operation codes, the handshake FSM states and a small op-class helper.
// Pure declarations: no clocked logic and no flow control here.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_PASSB = 5'd10,
    OP_MUL   = 5'd11,
    OP_MULHU = 5'd12,
    OP_DIV   = 5'd13,
    OP_DIVU  = 5'd14,
    OP_REM   = 5'd15,
    OP_REMU  = 5'd16
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Ops that are served by the iterative multiply/divide datapath.
  function automatic logic is_muldiv(alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operand/result handshake bundle between the issue stage and the ALU/MDU.
// No latency of its own; it only groups the wires.
// master drives operands, kill and out_ready; slave returns in_ready and the result.
interface alu_mdu_if #(parameter int WIDTH = 32);

  logic                 in_valid;
  logic                 in_ready;
  alu_pkg::alu_op_e     op;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic                 kill;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 zero;

  modport master (
    output in_valid, op, src_a, src_b, kill, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, src_a, src_b, kill, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/alu_mdu_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
// Latency: WIDTH steps after start; done pulses combinationally on the last step with res valid.
// No backpressure: once started it runs to completion unless kill aborts it.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic             sel_div,
  input  logic             signed_op,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int SHW = $clog2(WIDTH);

  logic             busy;
  logic             div_q;
  logic             hi_q;
  logic             neg_q;
  logic             neg_r;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;     // product high half / partial remainder
  logic [WIDTH-1:0] sr;      // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opd;     // multiplicand / divisor magnitude

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] sr_n;

  // Signed divide works on magnitudes; the sign is restored at the end.
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  // One multiply or divide step, plus the sign fix-up seen on the final step.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, (sr[0] ? opd : {WIDTH{1'b0}})};
    shl   = {acc, sr[WIDTH-1]};
    diff  = shl - {1'b0, opd};
    acc_n = acc;
    sr_n  = sr;
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_n = diff[WIDTH-1:0];
        sr_n  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shl[WIDTH-1:0];
        sr_n  = {sr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = sum[WIDTH:1];
      sr_n  = {sum[0], sr[WIDTH-1:1]};
    end
    if (div_q) begin
      res = hi_q ? (neg_r ? -acc_n : acc_n) : (neg_q ? -sr_n : sr_n);
    end else begin
      res = hi_q ? acc_n : sr_n;
    end
  end

  assign done = busy && (cnt == '0);

  // Operand capture on start, then one step per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sr    <= '0;
      opd   <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= sel_div;
      hi_q  <= sel_hi;
      neg_q <= sel_div && signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sel_div && signed_op && a[WIDTH-1];
      cnt   <= SHW'(WIDTH - 1);
      acc   <= '0;
      sr    <= sel_div ? a_mag : a;
      opd   <= sel_div ? b_mag : b;
    end else if (busy) begin
      acc <= acc_n;
      sr  <= sr_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative MUL/DIV behind a valid/ready handshake.
// Latency: 1 cycle for single-cycle ops and divide special cases, WIDTH+1 for MUL/DIV.
// Result is held in DONE until out_ready; new ops accepted only when the result drains.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_mdu_if.slave    bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             div_op;
  logic             signed_div;
  logic             div_zero;
  logic             div_ovf;
  logic             div_special;
  logic             go_iter;
  logic             sel_hi;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_res;

  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  // DONE counts as ready-to-accept so a drained result can be replaced back-to-back.
  assign bus.in_ready  = ((state == IDLE) || (state == DONE)) &&
                         (!bus.out_valid || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready && !bus.kill;

  // Divide-by-zero and MIN/-1 are resolved in the single-cycle path.
  assign div_op      = bus.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign signed_div  = bus.op inside {OP_DIV, OP_REM};
  assign div_zero    = (bus.src_b == '0);
  assign div_ovf     = signed_div && (bus.src_a == MIN_VAL) && (bus.src_b == '1);
  assign div_special = div_op && (div_zero || div_ovf);
  assign go_iter     = accept && is_muldiv(bus.op) && !div_special;
  assign sel_hi      = bus.op inside {OP_MULHU, OP_REM, OP_REMU};
  assign shamt       = bus.src_b[SHW-1:0];

  // Single-cycle ALU, including the divide special-case answers.
  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:   alu_res = bus.src_a + bus.src_b;
      OP_SUB:   alu_res = bus.src_a + ~bus.src_b + 1'b1;
      OP_AND:   alu_res = bus.src_a & bus.src_b;
      OP_OR:    alu_res = bus.src_a | bus.src_b;
      OP_XOR:   alu_res = bus.src_a ^ bus.src_b;
      OP_SLL:   alu_res = bus.src_a << shamt;
      OP_SRL:   alu_res = bus.src_a >> shamt;
      OP_SRA:   alu_res = WIDTH'($signed(bus.src_a) >>> shamt);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
      OP_PASSB: alu_res = bus.src_b;
      OP_DIV, OP_DIVU: alu_res = div_zero ? {WIDTH{1'b1}} : MIN_VAL;
      OP_REM, OP_REMU: alu_res = div_zero ? bus.src_a : {WIDTH{1'b0}};
      default:  alu_res = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (go_iter),
    .kill      (bus.kill),
    .sel_div   (div_op),
    .signed_op (signed_div),
    .sel_hi    (sel_hi),
    .a         (bus.src_a),
    .b         (bus.src_b),
    .done      (mdu_done),
    .res       (mdu_res)
  );

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: kill wins, then accept, then iteration completion or drain.
  always_comb begin
    state_n = state;
    if (bus.kill) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (go_iter) begin
              state_n = div_op ? DIV : MUL;
            end else begin
              state_n = DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state_n = IDLE;
          end
        end
        MUL, DIV: begin
          if (mdu_done) begin
            state_n = DONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Result/zero register; zero only ever reads 1 while the result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (bus.kill) begin
      zero_q <= 1'b0;
    end else if (accept && !go_iter) begin
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
    end else if (accept) begin
      zero_q <= 1'b0;
    end else if (mdu_done) begin
      result_q <= mdu_res;
      zero_q   <= (mdu_res == '0);
    end else if ((state == DONE) && bus.out_ready) begin
      zero_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu: single-cycle ops, MUL/DIV, divide corner cases,
// kill, result hold under backpressure, back-to-back accept and reset mid-multiply.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  alu_mdu_if #(.WIDTH(32)) bus ();

  alu_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input alu_op_e o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output logic rdy_seen);
    @(negedge clk);
    bus.op        = o;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = OP_PASSB;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    lat          = 1;
    rdy_seen     = bus.in_ready;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      rdy_seen |= bus.in_ready;
    end
    res = bus.result;
    z   = bus.zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    logic        rdy_seen;
    logic        flag;
    logic        rdy_any;

    n_chk = 0;
    n_err = 0;
    vecs = '{
      '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1},
      '{OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1},
      '{OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1},
      '{OP_SLTU,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1},
      '{OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1},
      '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1},
      '{OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1},
      '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1},
      '{OP_SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1},
      '{OP_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 1},
      '{OP_PASSB, 32'h00000000, 32'h00001234, 32'h00001234, 1},
      '{OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1},
      '{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33},
      '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
      '{OP_MUL,   32'h0000007B, 32'h000001C8, 32'h0000DB18, 33},
      '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
      '{OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
      '{OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1},
      '{OP_REM,   32'h00000007, 32'h00000000, 32'h00000007, 1},
      '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
      '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h0000000E, 33},
      '{OP_REMU,  32'h00000064, 32'h00000007, 32'h00000002, 33},
      '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
      '{OP_REM,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33}
    };

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result",    bus.result,    32'h0);
    chk("rst_zero",      bus.zero,      1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, rdy_seen);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_zero", i), z, (vecs[i].exp == 32'h0));
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) begin
        chk($sformatf("v%0d_in_ready_low", i), rdy_seen, 1'b0);
      end
    end

    // kill a divide mid-flight; the in_valid offered during kill must be dropped
    @(negedge clk);
    bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.kill = 1'b1; bus.in_valid = 1'b1; bus.op = OP_ADD; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.in_valid = 1'b0;
    chk("kill_in_ready", bus.in_ready, 1'b1);
    chk("kill_out_valid", bus.out_valid, 1'b0);
    flag = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      flag |= bus.out_valid;
    end
    chk("kill_no_valid", flag, 1'b0);
    run_op(OP_ADD, 32'd2, 32'd3, res, z, lat, rdy_seen);
    chk("post_kill_add", res, 32'd5);
    chk("post_kill_lat", lat, 1);

    // hold result under backpressure, then back-to-back accept
    @(negedge clk);
    bus.op = OP_ADD; bus.src_a = 32'd10; bus.src_b = 32'd20; bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flag    = 1'b1;
    rdy_any = 1'b0;
    repeat (4) begin
      if (bus.result !== 32'd30 || bus.out_valid !== 1'b1) flag = 1'b0;
      rdy_any |= bus.in_ready;
      @(posedge clk); #1;
    end
    chk("hold_stable", flag, 1'b1);
    chk("hold_in_ready_low", rdy_any, 1'b0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1; bus.op = OP_ADD; bus.src_a = 32'd1; bus.src_b = 32'd1;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_out_valid", bus.out_valid, 1'b1);
    chk("b2b_result", bus.result, 32'd2);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    bus.op = OP_MUL; bus.src_a = 32'd123; bus.src_b = 32'd456; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_result", bus.result, 32'h0);
    chk("midrst_zero", bus.zero, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MUL, 32'd3, 32'd5, res, z, lat, rdy_seen);
    chk("post_rst_mul", res, 32'd15);
    chk("post_rst_lat", lat, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
